// File: rtl/prog_clk_div_pkg.sv
// Shared constants and helpers for the programmable clock divider.
// Channel-count limits, divisor encoding and width/frequency helpers.
package prog_clk_div_pkg;

    localparam int MAX_CH  = 16;
    localparam int DIV_OFF = 0;

    // Width of a channel index; never narrower than one bit.
    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Half-period divisor that yields out_hz from clk_hz (0 when unreachable).
    function automatic longint half_period(input longint clk_hz, input longint out_hz);
        if (out_hz <= 0 || clk_hz < 2 * out_hz) begin
            return 0;
        end
        return clk_hz / (2 * out_hz);
    endfunction

endpackage

// File: rtl/div_channel.sv
// One divider channel: active/pending divisor, half-period counter,
// registered divided clock and rising-edge tick.
module div_channel
    import prog_clk_div_pkg::*;
#(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sync,
    input  logic             wr,
    input  logic [DIV_W-1:0] wr_div,
    output logic             pend_valid,
    output logic             clk_out,
    output logic             tick
);

    localparam logic [DIV_W-1:0] OFF = DIV_W'(DIV_OFF);
    localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

    logic [DIV_W-1:0] act;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] pend;
    logic             pv;

    logic [DIV_W-1:0] act_nxt;
    logic [DIV_W-1:0] cnt_nxt;
    logic [DIV_W-1:0] pend_nxt;
    logic             pv_nxt;
    logic             out_nxt;
    logic             tick_nxt;
    logic             apply;
    logic             at_end;

    assign at_end     = (cnt == act - ONE);
    assign pend_valid = pv;

    always_comb begin
        act_nxt  = act;
        cnt_nxt  = cnt;
        pend_nxt = pend;
        pv_nxt   = pv;
        out_nxt  = clk_out;
        tick_nxt = 1'b0;
        apply    = 1'b0;

        if (sync) begin
            cnt_nxt = '0;
            out_nxt = 1'b0;
            apply   = pv;
        end else if (act == OFF) begin
            cnt_nxt = '0;
            out_nxt = 1'b0;
            apply   = pv;
        end else if (at_end) begin
            cnt_nxt  = '0;
            out_nxt  = ~clk_out;
            tick_nxt = ~clk_out;
            // A new divisor only takes over on the high-to-low edge, so the
            // period in flight always completes with its original timing.
            apply    = pv & clk_out;
        end else begin
            cnt_nxt = cnt + ONE;
        end

        if (apply) begin
            act_nxt = pend;
            pv_nxt  = 1'b0;
        end else if (wr && !pv) begin
            pend_nxt = wr_div;
            pv_nxt   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            act     <= '0;
            cnt     <= '0;
            pend    <= '0;
            pv      <= 1'b0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
        end else begin
            act     <= act_nxt;
            cnt     <= cnt_nxt;
            pend    <= pend_nxt;
            pv      <= pv_nxt;
            clk_out <= out_nxt;
            tick    <= tick_nxt;
        end
    end

endmodule

// File: rtl/prog_clk_divider.sv
// Multi-channel programmable clock divider with glitch-free divisor updates
// and a common phase-alignment pulse.
module prog_clk_divider
    import prog_clk_div_pkg::*;
#(
    parameter int CLK_FREQ = 12_000_000,
    parameter int NUM_CH   = 4,
    parameter int DIV_W    = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      sync,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    input  logic [ch_w(NUM_CH)-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]          cfg_div,
    output logic [NUM_CH-1:0]         clk_out,
    output logic [NUM_CH-1:0]         tick
);

    localparam int CH_W     = ch_w(NUM_CH);
    localparam int CH_SLOTS = 1 << CH_W;

    if (NUM_CH < 1 || NUM_CH > MAX_CH || CLK_FREQ <= 0 || DIV_W < 1) begin : g_bad_params
        $error("prog_clk_divider: illegal parameter set");
    end

    logic [NUM_CH-1:0]   pv;
    logic [CH_SLOTS-1:0] pv_slot;
    logic [NUM_CH-1:0]   wr;

    // Unpopulated index slots read as "not pending", so writes to them
    // handshake normally and are dropped.
    always_comb begin
        pv_slot             = '0;
        pv_slot[NUM_CH-1:0] = pv;
        cfg_ready           = ~pv_slot[cfg_ch];
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign wr[i] = cfg_valid && cfg_ready && (cfg_ch == CH_W'(i));

        div_channel #(
            .DIV_W(DIV_W)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .sync       (sync),
            .wr         (wr[i]),
            .wr_div     (cfg_div),
            .pend_valid (pv[i]),
            .clk_out    (clk_out[i]),
            .tick       (tick[i])
        );
    end

endmodule
